data_bus_bridge: RTL and testbench
==================================

Name: data_bus_bridge

Overview:
- Sits directly downstream of the single-cycle CPU core's data-memory port (ALU result = address, register read data 2 = store data, DataMemRW decoded into rd/wr).
- Converts each single-cycle load/store into a valid/ready request toward a slower external data memory.
- Holds the core with a stall until the access completes, then returns load data.
- Adds a timeout, protocol and alignment checking, and a sticky error flag.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data word width.
- TIMEOUT_CYCLES, 64, max cycles spent in REQ+WAIT_RSP before aborting; must be >= 2.
- ERR_DATA, 32'hDEAD_BEEF, load data returned on any aborted or rejected access.

Ports:
- clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- cpu_rd  input  1  load requested this cycle.
- cpu_wr  input  1  store requested this cycle.
- cpu_addr  input  ADDR_W  byte address; must be word-aligned.
- cpu_wdata  input  DATA_W  store data.
- cpu_rdata  output  DATA_W  load data; valid when cpu_stall=0 in DONE.
- cpu_stall  output  1  core must hold PC and register writes while high.
- mem_req_valid  output  1  request valid.
- mem_req_ready  input  1  memory accepts request.
- mem_req_we  output  1  1=write, 0=read.
- mem_addr  output  ADDR_W  registered request address.
- mem_wdata  output  DATA_W  registered write data.
- mem_rsp_valid  input  1  read response valid (single cycle, no backpressure).
- mem_rsp_data  input  DATA_W  read response data.
- bus_err  output  1  sticky error flag; cleared only by Reset.

Behaviour:
- Reset values: state=IDLE, mem_req_valid=0, mem_req_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, bus_err=0, timeout counter=0. Reset mid-access drops the transaction; a late mem_rsp_valid is then ignored.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE, no access requested:
  - stays in IDLE; cpu_stall=0.
- IDLE, access requested:
  - cpu_stall=1 combinationally in the same cycle.
  - If cpu_rd&cpu_wr, or cpu_addr[1:0]!=0: go to DONE, set bus_err, cpu_rdata=ERR_DATA, no bus activity.
  - Otherwise: latch addr/wdata/we into mem_* registers, go to REQ, counter=0.
- REQ:
  - mem_req_valid=1; mem_addr, mem_wdata and mem_req_we held stable until accepted.
  - On mem_req_ready: drop valid next cycle. Write goes to DONE (posted, no response). Read goes to WAIT_RSP.
- WAIT_RSP:
  - On mem_rsp_valid: cpu_rdata<=mem_rsp_data, go to DONE.
  - A response that coincides with the ready cycle in REQ is not possible; the memory responds at least 1 cycle after acceptance.
- Timeout:
  - Counter increments every cycle in REQ or WAIT_RSP.
  - When it reaches TIMEOUT_CYCLES-1 without completion: go to DONE, set bus_err, cpu_rdata=ERR_DATA, drop mem_req_valid.
  - If ready or rsp arrives in that same cycle, completion wins and no error is flagged.
- DONE:
  - cpu_stall=0 for exactly one cycle; the core retires the instruction at that edge.
  - Unconditionally return to IDLE; the inputs still presented in DONE are not re-issued.
  - cpu_rdata holds its value until the next load completes.
- Stray mem_rsp_valid in IDLE/REQ/DONE: ignored; no error.
- cpu_stall is 1 in REQ and WAIT_RSP regardless of inputs.
- Latency:
  - Minimum load: 4 cycles stalled-inclusive (IDLE, REQ with ready, WAIT with rsp, DONE).
  - Minimum store: 3 cycles.

Decomposition:
- Shared package holds:
  - state enum encoding (IDLE=2'd0, REQ=2'd1, WAIT_RSP=2'd2, DONE=2'd3);
  - default ERR_DATA constant;
  - the DataMemRW to rd/wr decode convention used by the core's control unit.
- One natural sub-module: bridge_timeout_counter (clear/enable/expire, width $clog2(TIMEOUT_CYCLES)).

Test Plan:
- Aligned load addr=32'h10, memory ready immediately, rsp 2 cycles later with 32'hCAFE0001 -> stall high 4 cycles, cpu_rdata=32'hCAFE0001 in DONE, bus_err=0.
- Store addr=32'h20 data=32'h12345678, ready delayed 3 cycles -> mem_addr/mem_wdata/mem_req_we stable while valid, single handshake, stall drops after acceptance+1.
- Load addr=32'h22 (misaligned) -> no mem_req_valid ever, one DONE cycle, cpu_rdata=32'hDEADBEEF, bus_err=1 and stays 1 through later good accesses.
- Load with memory never responding, TIMEOUT_CYCLES=8 -> DONE after 8 counted cycles, bus_err=1, a subsequent late rsp is ignored, next load completes normally.
- Reset asserted while in WAIT_RSP -> all outputs at reset values next cycle; rsp arriving afterward does not change cpu_rdata.
- cpu_rd=cpu_wr=1 simultaneously -> rejected as protocol error, no bus activity, bus_err=1.

Source files
------------

// File: rtl/data_bus_bridge_pkg.sv
// Shared types and constants for the CPU data-port to valid/ready memory bridge.
// Holds the FSM encoding, the default error word and the core's DataMemRW decode.
package data_bus_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } bridge_state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // DataMemRW encoding produced by the core's control unit.
    typedef enum logic [1:0] {
        MEM_RW_NONE  = 2'b00,
        MEM_RW_READ  = 2'b01,
        MEM_RW_WRITE = 2'b10
    } data_mem_rw_t;

    typedef struct packed {
        logic rd;
        logic wr;
    } mem_cmd_t;

    function automatic mem_cmd_t decode_data_mem_rw(input data_mem_rw_t rw);
        mem_cmd_t cmd;
        cmd.rd = (rw == MEM_RW_READ);
        cmd.wr = (rw == MEM_RW_WRITE);
        return cmd;
    endfunction

endpackage

// File: rtl/data_bus_bridge_timeout_counter.sv
// Cycle counter bounding how long one access may spend on the memory bus.
// expire is asserted in the enabled cycle where the count reaches TIMEOUT_CYCLES-1.
module bridge_timeout_counter #(
    parameter int  TIMEOUT_CYCLES = 64,
    localparam int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign expire = enable && (cnt_q == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/data_bus_bridge.sv
// Turns single-cycle CPU loads/stores into valid/ready memory transactions,
// stalling the core until completion, with timeout, alignment and protocol checks.
module data_bus_bridge
    import data_bus_bridge_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                TIMEOUT_CYCLES = 64,
    parameter logic [DATA_W-1:0] ERR_DATA       = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              bus_err
);

    bridge_state_t     state_q,     state_d;
    logic              req_valid_q, req_valid_d;
    logic              req_we_q,    req_we_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;
    logic              bus_err_q,   bus_err_d;

    logic cpu_access;
    logic bad_access;
    logic tmo_expire;

    assign cpu_access = cpu_rd | cpu_wr;
    assign bad_access = (cpu_rd & cpu_wr) | (cpu_addr[1:0] != 2'b00);

    bridge_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .Reset  (Reset),
        .clear  (state_q == IDLE),
        .enable ((state_q == REQ) || (state_q == WAIT_RSP)),
        .expire (tmo_expire)
    );

    // NOTE: every always_comb output starts from a hold default so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_we_d    = req_we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        bus_err_d   = bus_err_q;

        unique case (state_q)
            IDLE: begin
                if (cpu_access) begin
                    if (bad_access) begin
                        state_d   = DONE;
                        bus_err_d = 1'b1;
                        rdata_d   = ERR_DATA;
                    end else begin
                        state_d     = REQ;
                        req_valid_d = 1'b1;
                        req_we_d    = cpu_wr;
                        addr_d      = cpu_addr;
                        wdata_d     = cpu_wdata;
                    end
                end
            end
            // Completion is checked before expiry so a last-cycle handshake is not flagged.
            REQ: begin
                if (mem_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = req_we_q ? DONE : WAIT_RSP;
                end else if (tmo_expire) begin
                    req_valid_d = 1'b0;
                    state_d     = DONE;
                    bus_err_d   = 1'b1;
                    rdata_d     = ERR_DATA;
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    rdata_d = mem_rsp_data;
                    state_d = DONE;
                end else if (tmo_expire) begin
                    state_d   = DONE;
                    bus_err_d = 1'b1;
                    rdata_d   = ERR_DATA;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_we_q    <= req_we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Stall rises combinationally on a new access so the core never advances past it.
    assign cpu_stall     = ((state_q == IDLE) && cpu_access) ||
                           (state_q == REQ) || (state_q == WAIT_RSP);
    assign cpu_rdata     = rdata_q;
    assign mem_req_valid = req_valid_q;
    assign mem_req_we    = req_we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_data_bus_bridge.sv
// Directed self-checking bench for data_bus_bridge with TIMEOUT_CYCLES=8.
// Expected values are hand-derived cycle by cycle from the bridge behaviour.
module tb_data_bus_bridge;

    logic        clk;
    logic        Reset;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        bus_err;

    int checks;
    int failures;

    data_bus_bridge #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8),
        .ERR_DATA       (32'hDEAD_BEEF)
    ) dut (
        .clk           (clk),
        .Reset         (Reset),
        .cpu_rd        (cpu_rd),
        .cpu_wr        (cpu_wr),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .cpu_stall     (cpu_stall),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .bus_err       (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Reset         = 1'b1;
        cpu_rd        = 1'b0;
        cpu_wr        = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        #1;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        cpu_addr      = '0;
        cpu_wdata     = '0;
        mem_rsp_data  = '0;
        do_reset();

        check("rst_valid", 32'(mem_req_valid), 32'd0);
        check("rst_we",    32'(mem_req_we),    32'd0);
        check("rst_addr",  mem_addr,           32'd0);
        check("rst_wdata", mem_wdata,          32'd0);
        check("rst_rdata", cpu_rdata,          32'd0);
        check("rst_err",   32'(bus_err),       32'd0);
        check("rst_stall", 32'(cpu_stall),     32'd0);

        // Aligned load, ready at once, response two cycles after acceptance.
        tick();
        cpu_rd = 1'b1; cpu_addr = 32'h10; #1;
        check("ld_idle_stall", 32'(cpu_stall), 32'd1);
        check("ld_idle_valid", 32'(mem_req_valid), 32'd0);
        tick();
        mem_req_ready = 1'b1; #1;
        check("ld_req_valid", 32'(mem_req_valid), 32'd1);
        check("ld_req_addr",  mem_addr, 32'h10);
        check("ld_req_we",    32'(mem_req_we), 32'd0);
        check("ld_req_stall", 32'(cpu_stall), 32'd1);
        tick();
        mem_req_ready = 1'b0; #1;
        check("ld_wait_valid", 32'(mem_req_valid), 32'd0);
        check("ld_wait_stall", 32'(cpu_stall), 32'd1);
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_0001; #1;
        check("ld_wait2_stall", 32'(cpu_stall), 32'd1);
        tick();
        mem_rsp_valid = 1'b0; #1;
        check("ld_done_stall", 32'(cpu_stall), 32'd0);
        check("ld_done_rdata", cpu_rdata, 32'hCAFE_0001);
        check("ld_done_err",   32'(bus_err), 32'd0);
        tick();
        cpu_rd = 1'b0; #1;
        check("ld_no_reissue", 32'(mem_req_valid), 32'd0);

        // Store with ready held off for three cycles; CPU inputs wander meanwhile.
        tick();
        cpu_wr = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h1234_5678; #1;
        check("st_idle_stall", 32'(cpu_stall), 32'd1);
        tick();
        cpu_addr = 32'hFFFF_FFF0; cpu_wdata = 32'h0; #1;
        check("st_req_valid", 32'(mem_req_valid), 32'd1);
        check("st_req_we",    32'(mem_req_we), 32'd1);
        check("st_req_addr",  mem_addr, 32'h20);
        check("st_req_wdata", mem_wdata, 32'h1234_5678);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("st_hold_valid", 32'(mem_req_valid), 32'd1);
            check("st_hold_addr",  mem_addr, 32'h20);
            check("st_hold_wdata", mem_wdata, 32'h1234_5678);
            check("st_hold_stall", 32'(cpu_stall), 32'd1);
        end
        tick();
        mem_req_ready = 1'b1; #1;
        check("st_acc_valid", 32'(mem_req_valid), 32'd1);
        check("st_acc_stall", 32'(cpu_stall), 32'd1);
        tick();
        mem_req_ready = 1'b0; #1;
        check("st_done_valid", 32'(mem_req_valid), 32'd0);
        check("st_done_stall", 32'(cpu_stall), 32'd0);
        check("st_done_rdata_held", cpu_rdata, 32'hCAFE_0001);
        tick();
        cpu_wr = 1'b0; #1;
        check("st_no_reissue", 32'(mem_req_valid), 32'd0);

        // Reset while waiting for a read response; the late response is dropped.
        tick();
        cpu_rd = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hAAAA_5555; #1;
        tick();
        mem_req_ready = 1'b1; #1;
        tick();
        mem_req_ready = 1'b0; #1;
        check("rw_wait_stall", 32'(cpu_stall), 32'd1);
        Reset = 1'b1; cpu_rd = 1'b0;
        tick();
        Reset = 1'b0; #1;
        check("rw_valid", 32'(mem_req_valid), 32'd0);
        check("rw_we",    32'(mem_req_we), 32'd0);
        check("rw_addr",  mem_addr, 32'd0);
        check("rw_wdata", mem_wdata, 32'd0);
        check("rw_rdata", cpu_rdata, 32'd0);
        check("rw_err",   32'(bus_err), 32'd0);
        check("rw_stall", 32'(cpu_stall), 32'd0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h7777_7777;
        tick();
        mem_rsp_valid = 1'b0; #1;
        check("rw_late_rsp_rdata", cpu_rdata, 32'd0);
        check("rw_late_rsp_stall", 32'(cpu_stall), 32'd0);

        // Response lands exactly on the last counted cycle: completion wins.
        tick();
        cpu_rd = 1'b1; cpu_addr = 32'h50; #1;
        tick();
        mem_req_ready = 1'b1; #1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            mem_req_ready = 1'b0;
            if (i == 7) begin
                mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBEEF_0007;
            end
            #1;
            check("edge_wait_stall", 32'(cpu_stall), 32'd1);
        end
        tick();
        mem_rsp_valid = 1'b0; #1;
        check("edge_done_stall", 32'(cpu_stall), 32'd0);
        check("edge_done_rdata", cpu_rdata, 32'hBEEF_0007);
        check("edge_done_err",   32'(bus_err), 32'd0);
        tick();
        cpu_rd = 1'b0; #1;

        // No response at all: 8 counted cycles then an aborted load.
        tick();
        cpu_rd = 1'b1; cpu_addr = 32'h60; #1;
        tick();
        mem_req_ready = 1'b1; #1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            mem_req_ready = 1'b0; #1;
            check("tmo_wait_stall", 32'(cpu_stall), 32'd1);
            check("tmo_wait_err",   32'(bus_err), 32'd0);
        end
        tick();
        check("tmo_done_stall", 32'(cpu_stall), 32'd0);
        check("tmo_done_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("tmo_done_err",   32'(bus_err), 32'd1);
        check("tmo_done_valid", 32'(mem_req_valid), 32'd0);
        tick();
        cpu_rd = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_5555; #1;
        tick();
        mem_rsp_valid = 1'b0; #1;
        check("tmo_late_rsp_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("tmo_late_rsp_valid", 32'(mem_req_valid), 32'd0);

        // Next load completes normally; the error flag stays set.
        cpu_rd = 1'b1; cpu_addr = 32'h64; #1;
        tick();
        mem_req_ready = 1'b1; #1;
        check("nl_req_addr", mem_addr, 32'h64);
        tick();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h6464_6464; #1;
        tick();
        mem_rsp_valid = 1'b0; #1;
        check("nl_done_stall", 32'(cpu_stall), 32'd0);
        check("nl_done_rdata", cpu_rdata, 32'h6464_6464);
        check("nl_done_err",   32'(bus_err), 32'd1);
        tick();
        cpu_rd = 1'b0; #1;

        // Simultaneous read and write is a protocol error with no bus activity.
        do_reset();
        check("rdwr_rst_err", 32'(bus_err), 32'd0);
        tick();
        cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h70; #1;
        check("rdwr_idle_stall", 32'(cpu_stall), 32'd1);
        check("rdwr_idle_valid", 32'(mem_req_valid), 32'd0);
        tick();
        check("rdwr_done_stall", 32'(cpu_stall), 32'd0);
        check("rdwr_done_valid", 32'(mem_req_valid), 32'd0);
        check("rdwr_done_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("rdwr_done_err",   32'(bus_err), 32'd1);
        tick();
        cpu_rd = 1'b0; cpu_wr = 1'b0; #1;
        check("rdwr_after_valid", 32'(mem_req_valid), 32'd0);

        // Misaligned load, then a good store: the error flag is sticky.
        do_reset();
        check("mis_rst_err", 32'(bus_err), 32'd0);
        tick();
        cpu_rd = 1'b1; cpu_addr = 32'h22; #1;
        check("mis_idle_stall", 32'(cpu_stall), 32'd1);
        check("mis_idle_valid", 32'(mem_req_valid), 32'd0);
        tick();
        check("mis_done_stall", 32'(cpu_stall), 32'd0);
        check("mis_done_valid", 32'(mem_req_valid), 32'd0);
        check("mis_done_addr",  mem_addr, 32'd0);
        check("mis_done_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("mis_done_err",   32'(bus_err), 32'd1);
        tick();
        cpu_rd = 1'b0; #1;
        check("mis_after_valid", 32'(mem_req_valid), 32'd0);
        tick();
        cpu_wr = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'h0BAD_F00D; #1;
        tick();
        mem_req_ready = 1'b1; #1;
        check("gs_req_valid", 32'(mem_req_valid), 32'd1);
        check("gs_req_addr",  mem_addr, 32'h80);
        check("gs_req_wdata", mem_wdata, 32'h0BAD_F00D);
        tick();
        mem_req_ready = 1'b0; #1;
        check("gs_done_stall", 32'(cpu_stall), 32'd0);
        check("gs_done_err",   32'(bus_err), 32'd1);
        tick();
        cpu_wr = 1'b0; #1;
        check("gs_after_err", 32'(bus_err), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
